// File: rtl/spi_slave_shifter.sv
// ----------------------------------------------------------------------------
// spi_slave_shifter
//
// SPI slave for the far end of the APB SPI master link. The SPI pins are
// oversampled in the PCLK domain: each pin passes through a synchroniser, and
// sclk edges are found by comparing the synchronised sclk with a delayed copy.
// Full-duplex DATA_WIDTH-bit frames are shifted in both directions. The local
// side sees a one-entry TX buffer and an RX holding register.
//
// Parameters:
//   DATA_WIDTH   frame length in bits (>= 2)
//   SYNC_STAGES  flops in each pin synchroniser (>= 2)
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   spi_en              slave enable (low behaves as ss deasserted)
//   cpol, cpha          SPI mode (change only while idle)
//   lsbfe               LSB-first select (only with SPI_SLAVE_LSBFE_EN)
//   sclk_in, ss_n_in,
//   mosi_in             asynchronous SPI pins
//   miso, miso_oe       registered serial output and its enable
//   tx_data, tx_valid,
//   tx_ready            one-entry TX buffer write port
//   tx_underrun         pulse: frame loaded while the buffer was empty
//   rx_data, rx_valid,
//   rx_ack              last received frame, unread flag, and its clear
//   rx_overrun          pulse: frame completed while rx_valid was set
//   busy                frame in progress (bit counter non-zero)
//
// Build option:
//   SPI_SLAVE_LSBFE_EN  adds the lsbfe input for LSB-first transfers.
// ----------------------------------------------------------------------------
module spi_slave_shifter #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  spi_en,
    input  logic                  cpol,
    input  logic                  cpha,
`ifdef SPI_SLAVE_LSBFE_EN
    input  logic                  lsbfe,
`endif
    input  logic                  sclk_in,
    input  logic                  ss_n_in,
    input  logic                  mosi_in,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Bit order select
    // ------------------------------------------------------------------
    logic lsb_first;
`ifdef SPI_SLAVE_LSBFE_EN
    assign lsb_first = lsbfe;
`else
    assign lsb_first = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pin synchronisers. mosi has the same depth as sclk so the data bit
    // seen in the edge-detect cycle is the one the master presented at
    // that pin edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;

    always_ff @(posedge PCLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge value of its source, independent of statement order.
        if (PRESET) begin
            sclk_sync_q <= {SYNC_STAGES{cpol}};
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= cpol;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, ss_n_s, mosi_s;
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_n_s = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge classification. Leading edge leaves the idle level.
    // ------------------------------------------------------------------
    logic rise, fall, leading, trailing, sample_edge, shift_edge;
    assign rise        = sclk_s & ~sclk_prev_q;
    assign fall        = ~sclk_s & sclk_prev_q;
    assign leading     = cpol ? fall : rise;
    assign trailing    = cpol ? rise : fall;
    assign sample_edge = cpha ? trailing : leading;
    assign shift_edge  = cpha ? leading : trailing;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_full_q, tx_full_d;
    logic                    complete_q, complete_d;
    logic                    underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    miso_q, miso_d;

    logic active_ok, load, accept;
    assign active_ok = spi_en & ~ss_n_s;
    assign accept    = tx_valid & ~tx_full_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a variable unassigned (no latches).
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        complete_d = 1'b0;
        underrun_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Nothing survives idle: miso shows a clean 0 between
                // transfers and any partial frame is discarded.
                tx_shift_d = '0;
                rx_shift_d = '0;
                bit_cnt_d  = '0;
                if (active_ok) begin
                    state_d = ACTIVE;
                    // With cpha=0 the first bit must be on miso before the
                    // first (sampling) edge, so load on select.
                    load    = ~cpha;
                end
            end
            ACTIVE: begin
                if (!active_ok) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                end else begin
                    if (shift_edge) begin
                        if (bit_cnt_q == '0) begin
                            load = 1'b1;
                        end else if (lsb_first) begin
                            tx_shift_d = {1'b1, tx_shift_q[DATA_WIDTH-1:1]};
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b1};
                        end
                    end
                    if (sample_edge) begin
                        rx_shift_d = lsb_first ? {mosi_s, rx_shift_q[DATA_WIDTH-1:1]}
                                               : {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            complete_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load takes the buffer as it was before this edge; an empty buffer
        // sends all-ones (idle-high line) and flags an underrun.
        if (load) begin
            tx_shift_d = tx_full_q ? tx_buf_q : '1;
            underrun_d = ~tx_full_q;
        end

        // Accept is only possible while empty, so a same-cycle load has
        // already seen the empty buffer and the new word stays stored.
        if (accept) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end else if (load) begin
            tx_full_d = 1'b0;
        end

        // Completion has priority over rx_ack.
        if (complete_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        miso_d = lsb_first ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            complete_q <= 1'b0;
            underrun_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            complete_q <= complete_d;
            underrun_q <= underrun_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            miso_q     <= miso_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = (state_q == ACTIVE);
    assign tx_ready    = ~tx_full_q;
    assign tx_underrun = underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = overrun_q;
    assign busy        = (bit_cnt_q != '0);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_shifter
//
// Drives the slave as an SPI master with a slow sclk (8 PCLK per half period).
// Expected received frames are queued by the stimulus; a monitor pops and
// compares whenever rx_data is (re)written. miso words and status are checked
// directly by the stimulus against hand-computed values.
// ----------------------------------------------------------------------------
module tb_spi_slave_shifter;

    localparam int DW = 8;
    localparam int HP = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          ov;
    } rx_exp_t;

    logic          PCLK;
    logic          PRESET;
    logic          spi_en;
    logic          cpol;
    logic          cpha;
    logic          sclk_in;
    logic          ss_n_in;
    logic          mosi_in;
    logic          miso;
    logic          miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_underrun;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ack;
    logic          rx_overrun;
    logic          busy;

    int      checks;
    int      errors;
    int      underrun_cnt;
    int      overrun_cnt;
    rx_exp_t rx_exp_q[$];

    spi_slave_shifter #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .spi_en     (spi_en),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk_in    (sclk_in),
        .ss_n_in    (ss_n_in),
        .mosi_in    (mosi_in),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},        32'(miso),        32'h0);
        check({tag, "_miso_oe"},     32'(miso_oe),     32'h0);
        check({tag, "_tx_ready"},    32'(tx_ready),    32'h1);
        check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'h0);
        check({tag, "_rx_data"},     32'(rx_data),     32'h0);
        check({tag, "_rx_valid"},    32'(rx_valid),    32'h0);
        check({tag, "_rx_overrun"},  32'(rx_overrun),  32'h0);
        check({tag, "_busy"},        32'(busy),        32'h0);
    endtask

    // Scoreboard monitor: a new rx word is presented when rx_valid rises,
    // or when an overrun overwrites a still-valid word.
    task automatic monitor();
        logic    prev;
        rx_exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge PCLK);
            if (tx_underrun) underrun_cnt++;
            if (rx_overrun) overrun_cnt++;
            if (rx_valid && (!prev || rx_overrun)) begin
                if (rx_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_rx_unexpected: got rx_data 0x%0h, required no frame at %0t",
                             rx_data, $time);
                end else begin
                    e = rx_exp_q.pop_front();
                    check("sb_rx_data",    32'(rx_data),    32'(e.data));
                    check("sb_rx_overrun", 32'(rx_overrun), 32'(e.ov));
                end
            end
            prev = rx_valid;
        end
    endtask

    task automatic watchdog();
        wait_cyc(60000);
        $display("FAIL watchdog: simulation exceeded cycle budget, required completion");
        $fatal(1, "watchdog expired");
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cpol    = pol;
        cpha    = pha;
        sclk_in = pol;
        wait_cyc(6);
    endtask

    task automatic write_tx(input logic [DW-1:0] v);
        @(negedge PCLK);
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge PCLK);
        tx_valid = 1'b0;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        wait_cyc(1);
        rx_ack = 1'b0;
        check("rx_valid_after_ack", 32'(rx_valid), 32'h0);
    endtask

    // Master side of nbits of a frame, MSB first. Returns the miso bits.
    task automatic xfer(input logic [DW-1:0] mo, input int nbits, input bit chk_pre,
                        output logic [DW-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_in = mo[DW-1-i];
                wait_cyc(HP);
                sclk_in = ~cpol;
                mi      = {mi[DW-2:0], miso};
                wait_cyc(HP);
                sclk_in = cpol;
            end else begin
                if (chk_pre && i == 0) check("miso_before_first_shift", 32'(miso), 32'h0);
                sclk_in = ~cpol;
                mosi_in = mo[DW-1-i];
                wait_cyc(HP);
                sclk_in = cpol;
                mi      = {mi[DW-2:0], miso};
                wait_cyc(HP);
            end
        end
    endtask

    task automatic end_frame();
        wait_cyc(HP);
        ss_n_in = 1'b1;
        wait_cyc(HP);
    endtask

    initial begin
        logic [DW-1:0] mi;
        logic [DW-1:0] mi2;
        logic [1:0]    md;
        int            u0;
        int            o0;

        checks       = 0;
        errors       = 0;
        underrun_cnt = 0;
        overrun_cnt  = 0;
        PRESET   = 1'b1;
        spi_en   = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        sclk_in  = 1'b0;
        ss_n_in  = 1'b1;
        mosi_in  = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ack   = 1'b0;

        fork
            monitor();
            watchdog();
        join_none

        wait_cyc(3);
        check_reset_outputs("reset");
        PRESET = 1'b0;
        wait_cyc(2);

        // Mode 0: slave sends 0xA5, master sends 0x3C.
        set_mode(1'b0, 1'b0);
        write_tx(8'hA5);
        check("tx_ready_after_accept", 32'(tx_ready), 32'h0);
        u0 = underrun_cnt;
        rx_exp_q.push_back('{8'h3C, 1'b0});
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        check("m0_tx_ready_after_ss", 32'(tx_ready), 32'h1);
        check("m0_miso_oe",           32'(miso_oe),  32'h1);
        xfer(8'h3C, DW, 1'b0, mi);
        check("m0_miso_word", 32'(mi), 32'hA5);
        end_frame();
        check("m0_miso_oe_idle",   32'(miso_oe),           32'h0);
        check("m0_underrun_count", 32'(underrun_cnt - u0), 32'h1);
        check("m0_rx_data",        32'(rx_data),           32'h3C);
        check("m0_rx_valid",       32'(rx_valid),          32'h1);
        do_ack();

        // Modes 1..3: slave 0x81, master 0x7E.
        for (int m = 1; m < 4; m++) begin
            md = 2'(m);
            set_mode(md[1], md[0]);
            write_tx(8'h81);
            u0 = underrun_cnt;
            rx_exp_q.push_back('{8'h7E, 1'b0});
            ss_n_in = 1'b0;
            wait_cyc(2 * HP);
            xfer(8'h7E, DW, 1'b1, mi);
            check("mode_miso_word", 32'(mi), 32'h81);
            end_frame();
            check("mode_underrun_count", 32'(underrun_cnt - u0), md[0] ? 32'h0 : 32'h1);
            check("mode_rx_data", 32'(rx_data), 32'h7E);
            do_ack();
        end

        // Back-to-back frames, second TX word written during frame 1.
        set_mode(1'b0, 1'b0);
        write_tx(8'h11);
        u0 = underrun_cnt;
        o0 = overrun_cnt;
        rx_exp_q.push_back('{8'hC3, 1'b0});
        rx_exp_q.push_back('{8'h96, 1'b1});
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        fork
            begin
                xfer(8'hC3, DW, 1'b0, mi);
                xfer(8'h96, DW, 1'b0, mi2);
            end
            begin
                wait_cyc(6 * HP);
                write_tx(8'h22);
            end
        join
        check("b2b_miso_word1", 32'(mi),  32'h11);
        check("b2b_miso_word2", 32'(mi2), 32'h22);
        end_frame();
        check("b2b_overrun_count",  32'(overrun_cnt - o0),  32'h1);
        check("b2b_underrun_count", 32'(underrun_cnt - u0), 32'h1);
        check("b2b_rx_data",        32'(rx_data),           32'h96);
        do_ack();

        // Empty TX buffer in mode 1: all-ones on miso, one underrun pulse.
        set_mode(1'b0, 1'b1);
        u0 = underrun_cnt;
        rx_exp_q.push_back('{8'hA3, 1'b0});
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        xfer(8'hA3, DW, 1'b1, mi);
        check("empty_miso_word", 32'(mi), 32'hFF);
        end_frame();
        check("empty_underrun_count", 32'(underrun_cnt - u0), 32'h1);
        do_ack();

        // Abort after 5 bits, then a full frame 0x5A.
        set_mode(1'b0, 1'b0);
        write_tx(8'hF0);
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        xfer(8'hC6, 5, 1'b0, mi);
        check("abort_busy_mid",   32'(busy),     32'h1);
        check("abort_miso_bits",  32'(mi),       32'h1E);
        ss_n_in = 1'b1;
        wait_cyc(2 * HP);
        check("abort_busy_after", 32'(busy),     32'h0);
        check("abort_no_rx",      32'(rx_valid), 32'h0);
        check("abort_miso_oe",    32'(miso_oe),  32'h0);
        write_tx(8'hC3);
        rx_exp_q.push_back('{8'h5A, 1'b0});
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        xfer(8'h5A, DW, 1'b0, mi);
        check("post_abort_miso_word", 32'(mi), 32'hC3);
        end_frame();
        check("post_abort_rx_data", 32'(rx_data), 32'h5A);
        do_ack();

        // PRESET in the middle of a frame, then a normal frame.
        write_tx(8'h99);
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        xfer(8'hE1, 4, 1'b0, mi);
        check("preset_busy_before", 32'(busy), 32'h1);
        PRESET = 1'b1;
        wait_cyc(1);
        check_reset_outputs("preset_mid");
        PRESET  = 1'b0;
        ss_n_in = 1'b1;
        wait_cyc(2 * HP);
        write_tx(8'h6B);
        rx_exp_q.push_back('{8'hE7, 1'b0});
        ss_n_in = 1'b0;
        wait_cyc(2 * HP);
        xfer(8'hE7, DW, 1'b0, mi);
        check("post_preset_miso_word", 32'(mi), 32'h6B);
        end_frame();
        check("post_preset_rx_data", 32'(rx_data), 32'hE7);
        do_ack();

        wait_cyc(10);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
- SPI slave (responder) for the far end of our APB SPI master link: receives sclk/ss/mosi, drives miso, all in the PCLK domain by oversampling.
- Synchronises the pins, detects sclk edges per cpol/cpha, and shifts DATA_WIDTH-bit frames in both directions.
- Presents a one-entry TX buffer and an RX holding register to the local register/APB side.

Parameters:
- DATA_WIDTH, 8: frame length in bits (≥2).
- SYNC_STAGES, 2: flops in each pin synchroniser (≥2).

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  synchronous active-high reset
- spi_en  in  1  slave enable; low behaves as ss deasserted
- cpol  in  1  clock idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- sclk_in  in  1  async SPI clock pin
- ss_n_in  in  1  async active-low select pin
- mosi_in  in  1  async data in
- miso  out  1  serial data out (registered)
- miso_oe  out  1  miso output enable
- tx_data  in  DATA_WIDTH  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX buffer empty
- tx_underrun  out  1  one-cycle pulse: frame loaded with an empty buffer
- rx_data  out  DATA_WIDTH  last received frame
- rx_valid  out  1  rx_data unread (level)
- rx_ack  in  1  clears rx_valid
- rx_overrun  out  1  one-cycle pulse: frame completed with rx_valid=1
- busy  out  1  frame in progress (bit_cnt≠0)

Behaviour:
- Reset, or any cycle with PRESET=1: miso=0, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, rx_overrun=0, busy=0. Synchronisers clear to sclk=cpol, ss_n=1, mosi=0. bit_cnt=0, state=IDLE.
- Synchronisers: all three pins pass through SYNC_STAGES flops, plus one registered copy of synced sclk for edge detection. mosi uses the same depth as sclk, so the sample stays aligned with the edge.
- Edges: leading = rising if cpol=0, falling if cpol=1; trailing is the opposite edge. The sample edge is leading if cpha=0, trailing if cpha=1. The other edge is the shift edge.
- Required sclk half-period ≥3 PCLK cycles.
- State machine:
  - IDLE → ACTIVE on synced ss_n=0 with spi_en=1.
  - ACTIVE → IDLE on synced ss_n=1 or spi_en=0.
  - sclk edges are ignored in IDLE.
- miso_oe=1 exactly while in ACTIVE. miso holds tx_shift[MSB].
- TX buffer:
  - Accepts on tx_valid && tx_ready; tx_ready falls the next cycle.
  - Load events:
    - IDLE→ACTIVE transition when cpha=0.
    - Every shift edge with bit_cnt==0.
  - On a load, tx_shift takes the buffer and tx_ready returns to 1.
  - If the buffer is empty at a load, tx_shift is all-ones and tx_underrun pulses.
  - A load and an accept in the same cycle: the load takes the old contents and the new word is stored.
- Shift edge with bit_cnt≠0: tx_shift shifts left by one, filling with 1.
- Sample edge:
  - rx_shift ← {rx_shift[DATA_WIDTH-2:0], mosi_sync}.
  - bit_cnt increments, wrapping DATA_WIDTH-1→0.
- Frame completion (sample edge with bit_cnt==DATA_WIDTH-1):
  - On the next cycle, rx_data gets the full assembled word and rx_valid=1.
  - If rx_valid was already 1, the data is overwritten and rx_overrun pulses.
  - rx_ack in the same cycle as completion: completion wins, so rx_valid stays 1 and there is no overrun.
- Back-to-back frames with ss_n held low are supported with no gap; the next word loads on the first shift edge after wrap.
- ss_n deasserts mid-frame: bit_cnt→0, partial rx discarded, no rx_valid, and the word in tx_shift is lost (not returned to the buffer). The buffer itself is kept.
- cpol/cpha changes are only legal in IDLE.
- Latency: rx_valid rises SYNC_STAGES+2 PCLK cycles after the final pin sample edge. miso changes SYNC_STAGES+2 cycles after the pin shift edge.

Optional Feature:
- SPI_SLAVE_LSBFE_EN defined: adds input lsbfe (1 bit, legal to change only in IDLE).
  - When lsbfe=1, tx shifts right and miso is tx_shift[0].
  - rx shifts in at the MSB, so rx_data is in natural bit order.
- Undefined: no port; MSB-first only.

Test Plan:
- cpol=0, cpha=0, tx_data=0xA5 preloaded, master sends 0x3C → miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1; tx_ready=1 after ss assert.
- Modes 1, 2 and 3, each with tx 0x81 and master 0x7E → exchange correct in each mode, and the first miso bit appears only after the first shift edge when cpha=1.
- Two back-to-back frames with ss low, tx 0x11 then 0x22 (second written mid-frame 1), no rx_ack → second completion gives rx_overrun pulse and rx_data=0x(second word).
- Empty TX buffer, ss asserted, 8 clocks → miso all 1s; tx_underrun one pulse.
- ss_n released after 5 sclk periods, then a full frame with 0x5A → no rx_valid after the abort; next frame rx_data=0x5A, bit alignment correct.
- PRESET=1 mid-frame → all outputs at reset values the next cycle; a following frame works normally.
